// File: rtl/common_pkg.sv
// Shared types for the EX/MEM boundary: FSM state encoding and the payload bundle
// that travels from EX into MEM as a single register.
package common_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        ALU_WAIT = 2'd1,
        MEM_HOLD = 2'd2
    } ex_mem_state_t;

    typedef struct packed {
        logic [XLEN-1:0]   alu_res;
        logic [XLEN-1:0]   store_data;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [2:0]        funct3;
    } ex_mem_bundle_t;

    // x0 is hardwired to zero, so a write to it must never be forwarded
    function automatic logic fwd_ok(input logic valid, input logic reg_write,
                                    input logic [REG_AW-1:0] rd);
        return valid & reg_write & (rd != '0);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with ALU multicycle bubble handling, memory stall hold,
// flush deferral and forwarding source. Optional macro STALL_COUNTERS_EN adds stall counters.
module ex_mem_reg
    import common_pkg::*;
#(
    parameter int DATA_W     = XLEN,
    parameter int REG_ADDR_W = REG_AW,
    parameter int MAX_BUBBLE = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     ex_alu_res,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [2:0]            ex_funct3,
    input  logic                  alu_insert_bubble,
    input  logic                  mem_stall,
    input  logic                  flush,
    output logic                  ex_stall,
    output logic                  mem_valid,
    output logic [DATA_W-1:0]     mem_alu_res,
    output logic [DATA_W-1:0]     mem_store_data,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic [2:0]            mem_funct3,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data,
`ifdef STALL_COUNTERS_EN
    output logic [31:0]           perf_alu_stall,
    output logic [31:0]           perf_mem_stall,
`endif
    output logic                  alu_timeout
);

    localparam int CNT_W = $clog2(MAX_BUBBLE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BUBBLE);

    ex_mem_state_t  state_q, state_d;
    ex_mem_bundle_t bundle_q, bundle_d, ex_bundle;
    logic           valid_q, valid_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic           flush_pending_q, flush_pending_d;
    logic           timeout_q, timeout_d;
    logic           ex_stall_c;
    logic           flush_eff;

    always_comb begin
        ex_bundle            = '0;
        ex_bundle.alu_res    = ex_alu_res;
        ex_bundle.store_data = ex_store_data;
        ex_bundle.rd         = ex_rd;
        ex_bundle.reg_write  = ex_reg_write;
        ex_bundle.mem_read   = ex_mem_read;
        ex_bundle.mem_write  = ex_mem_write;
        ex_bundle.funct3     = ex_funct3;
    end

    assign flush_eff = flush | flush_pending_q;

    // Priority: mem_stall, then flush (live or deferred), then ALU bubble, then capture
    always_comb begin
        state_d         = state_q;
        bundle_d        = bundle_q;
        valid_d         = valid_q;
        wait_cnt_d      = wait_cnt_q;
        flush_pending_d = flush_pending_q;
        timeout_d       = timeout_q;
        ex_stall_c      = 1'b0;

        if (mem_stall) begin
            state_d         = MEM_HOLD;
            ex_stall_c      = 1'b1;
            flush_pending_d = flush_pending_q | flush;
        end else if (flush_eff) begin
            state_d         = RUN;
            valid_d         = 1'b0;
            wait_cnt_d      = '0;
            flush_pending_d = 1'b0;
        end else begin
            unique case (state_q)
                ALU_WAIT: begin
                    ex_stall_c = alu_insert_bubble;
                    if (alu_insert_bubble) begin
                        valid_d = 1'b0;
                        if (wait_cnt_q != CNT_MAX) begin
                            wait_cnt_d = wait_cnt_q + 1'b1;
                        end
                        if (wait_cnt_d == CNT_MAX) begin
                            timeout_d = 1'b1;
                        end
                    end else begin
                        bundle_d   = ex_bundle;
                        valid_d    = 1'b1;
                        wait_cnt_d = '0;
                        state_d    = RUN;
                    end
                end
                default: begin
                    // MEM_HOLD with the stall released behaves exactly like RUN
                    state_d = RUN;
                    if (ex_valid && alu_insert_bubble) begin
                        ex_stall_c = 1'b1;
                        valid_d    = 1'b0;
                        wait_cnt_d = CNT_W'(1);
                        state_d    = ALU_WAIT;
                        if (wait_cnt_d == CNT_MAX) begin
                            timeout_d = 1'b1;
                        end
                    end else if (ex_valid) begin
                        bundle_d = ex_bundle;
                        valid_d  = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RUN;
            bundle_q        <= '0;
            valid_q         <= 1'b0;
            wait_cnt_q      <= '0;
            flush_pending_q <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            bundle_q        <= bundle_d;
            valid_q         <= valid_d;
            wait_cnt_q      <= wait_cnt_d;
            flush_pending_q <= flush_pending_d;
            timeout_q       <= timeout_d;
        end
    end

    // Stall request is suppressed while reset is held so every output reads 0
    assign ex_stall       = ex_stall_c & ~rst;
    assign mem_valid      = valid_q;
    assign mem_alu_res    = bundle_q.alu_res;
    assign mem_store_data = bundle_q.store_data;
    assign mem_rd         = bundle_q.rd;
    assign mem_reg_write  = bundle_q.reg_write;
    assign mem_mem_read   = bundle_q.mem_read;
    assign mem_mem_write  = bundle_q.mem_write;
    assign mem_funct3     = bundle_q.funct3;
    assign fwd_valid      = fwd_ok(valid_q, bundle_q.reg_write, bundle_q.rd);
    assign fwd_rd         = bundle_q.rd;
    assign fwd_data       = bundle_q.alu_res;
    assign alu_timeout    = timeout_q;

`ifdef STALL_COUNTERS_EN
    // Outside a memory stall, any stall request can only come from the ALU
    logic alu_stall_inc;
    assign alu_stall_inc = ex_stall_c & ~mem_stall;

    sat_counter #(.WIDTH(32)) u_perf_alu (
        .clk   (clk),
        .rst   (rst),
        .inc   (alu_stall_inc),
        .count (perf_alu_stall)
    );

    sat_counter #(.WIDTH(32)) u_perf_mem (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_stall),
        .count (perf_mem_stall)
    );
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed vector table, multi-cycle corner sequences, and
// randomized traffic checked against a rule-level reference model.
module tb_ex_mem_reg;

    localparam int MAXB = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_alu_res, ex_store_data;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        alu_insert_bubble, mem_stall, flush;
    logic        ex_stall, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
    logic [31:0] mem_alu_res, mem_store_data, fwd_data;
    logic [4:0]  mem_rd, fwd_rd;
    logic [2:0]  mem_funct3;
    logic        fwd_valid, alu_timeout;
`ifdef STALL_COUNTERS_EN
    logic [31:0] perf_alu_stall, perf_mem_stall;
`endif

    always #5 clk = ~clk;

    ex_mem_reg #(.DATA_W(32), .REG_ADDR_W(5), .MAX_BUBBLE(MAXB)) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_valid          (ex_valid),
        .ex_alu_res        (ex_alu_res),
        .ex_store_data     (ex_store_data),
        .ex_rd             (ex_rd),
        .ex_reg_write      (ex_reg_write),
        .ex_mem_read       (ex_mem_read),
        .ex_mem_write      (ex_mem_write),
        .ex_funct3         (ex_funct3),
        .alu_insert_bubble (alu_insert_bubble),
        .mem_stall         (mem_stall),
        .flush             (flush),
        .ex_stall          (ex_stall),
        .mem_valid         (mem_valid),
        .mem_alu_res       (mem_alu_res),
        .mem_store_data    (mem_store_data),
        .mem_rd            (mem_rd),
        .mem_reg_write     (mem_reg_write),
        .mem_mem_read      (mem_mem_read),
        .mem_mem_write     (mem_mem_write),
        .mem_funct3        (mem_funct3),
        .fwd_valid         (fwd_valid),
        .fwd_rd            (fwd_rd),
        .fwd_data          (fwd_data),
`ifdef STALL_COUNTERS_EN
        .perf_alu_stall    (perf_alu_stall),
        .perf_mem_stall    (perf_mem_stall),
`endif
        .alu_timeout       (alu_timeout)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic        bubble;
        logic        mstall;
        logic        flush;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        exp_stall;
        logic        exp_valid;
        logic [31:0] exp_res;
        logic        exp_fwd;
        logic [4:0]  exp_rd;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, expressed in terms of the behavioural rules
    logic    m_valid;
    stim_t   m_cap;
    bit      m_waiting;
    int      m_waited;
    bit      m_kill;
    bit      m_timeout;
    longint  m_palu, m_pmem;

    function automatic stim_t mk(input logic v, input logic [31:0] res,
                                 input logic [4:0] rd, input logic rw);
        stim_t s;
        s     = '0;
        s.v   = v;
        s.res = res;
        s.sd  = ~res;
        s.rd  = rd;
        s.rw  = rw;
        s.f3  = 3'd2;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        ex_valid          = s.v;
        ex_alu_res        = s.res;
        ex_store_data     = s.sd;
        ex_rd             = s.rd;
        ex_reg_write      = s.rw;
        ex_mem_read       = s.mr;
        ex_mem_write      = s.mw;
        ex_funct3         = s.f3;
        alu_insert_bubble = s.bubble;
        mem_stall         = s.mstall;
        flush             = s.flush;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic pre(input stim_t s);
        @(negedge clk);
        drive(s);
        #1;
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive('0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0; m_cap = '0; m_waiting = 0; m_waited = 0;
        m_kill = 0; m_timeout = 0; m_palu = 0; m_pmem = 0;
    endtask

    function automatic logic model_stall(input stim_t s);
        if (s.mstall) return 1'b1;
        if (s.flush || m_kill) return 1'b0;
        if (m_waiting) return s.bubble;
        return s.v & s.bubble;
    endfunction

    task automatic model_step(input stim_t s);
        if (s.mstall) begin
            m_kill    = m_kill | s.flush;
            m_waiting = 0;
            if (m_pmem < 64'hFFFF_FFFF) m_pmem++;
        end else if (s.flush || m_kill) begin
            m_valid = 1'b0; m_kill = 0; m_waiting = 0;
        end else if (m_waiting) begin
            if (s.bubble) begin
                m_valid = 1'b0;
                if (m_waited < MAXB) m_waited++;
                if (m_waited == MAXB) m_timeout = 1;
                if (m_palu < 64'hFFFF_FFFF) m_palu++;
            end else begin
                m_cap = s; m_valid = 1'b1; m_waiting = 0;
            end
        end else if (s.v && s.bubble) begin
            m_valid = 1'b0; m_waiting = 1; m_waited = 1;
            if (m_waited == MAXB) m_timeout = 1;
            if (m_palu < 64'hFFFF_FFFF) m_palu++;
        end else if (s.v) begin
            m_cap = s; m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        vec_t  tab [7];
        stim_t s;

        drive('0);
        tab[0] = '{mk(1'b1, 32'h0000_0042, 5'd5, 1'b1), 1'b0, 1'b1, 32'h0000_0042, 1'b1, 5'd5};
        tab[1] = '{mk(1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1), 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0};
        tab[2] = '{mk(1'b0, 32'h0000_1234, 5'd7, 1'b1), 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 5'd0};
        tab[3] = '{mk(1'b1, 32'h0000_1000, 5'd3, 1'b1), 1'b0, 1'b1, 32'h0000_1000, 1'b1, 5'd3};
        s = mk(1'b1, 32'h0000_5555, 5'd8, 1'b1); s.mstall = 1'b1;
        tab[4] = '{s, 1'b1, 1'b1, 32'h0000_1000, 1'b1, 5'd3};
        s = mk(1'b1, 32'h0000_0077, 5'd9, 1'b0); s.flush = 1'b1;
        tab[5] = '{s, 1'b0, 1'b0, 32'h0000_1000, 1'b0, 5'd3};
        tab[6] = '{mk(1'b1, 32'h0000_0088, 5'd10, 1'b1), 1'b0, 1'b1, 32'h0000_0088, 1'b1, 5'd10};

        do_reset();
        #1;
        chk("rst mem_valid", 32'(mem_valid), 32'd0);
        chk("rst mem_alu_res", mem_alu_res, 32'd0);
        chk("rst fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst alu_timeout", 32'(alu_timeout), 32'd0);
        chk("rst ex_stall", 32'(ex_stall), 32'd0);

        for (int i = 0; i < 7; i++) begin
            pre(tab[i].s);
            chk($sformatf("tab%0d ex_stall", i), 32'(ex_stall), 32'(tab[i].exp_stall));
            post();
            chk($sformatf("tab%0d mem_valid", i), 32'(mem_valid), 32'(tab[i].exp_valid));
            chk($sformatf("tab%0d mem_alu_res", i), mem_alu_res, tab[i].exp_res);
            chk($sformatf("tab%0d fwd_valid", i), 32'(fwd_valid), 32'(tab[i].exp_fwd));
            chk($sformatf("tab%0d fwd_rd", i), 32'(fwd_rd), 32'(tab[i].exp_rd));
        end

        // Six-cycle multicycle op, result presented as the bubble drops
        do_reset();
        for (int k = 0; k < 6; k++) begin
            s = mk(1'b1, 32'hDEAD_0000 + 32'(k), 5'd6, 1'b1); s.bubble = 1'b1;
            pre(s);
            chk($sformatf("mul%0d ex_stall", k), 32'(ex_stall), 32'd1);
            post();
            chk($sformatf("mul%0d mem_valid", k), 32'(mem_valid), 32'd0);
        end
        pre(mk(1'b1, 32'h0000_0C00, 5'd6, 1'b1));
        chk("mul drop ex_stall", 32'(ex_stall), 32'd0);
        post();
        chk("mul mem_valid", 32'(mem_valid), 32'd1);
        chk("mul mem_alu_res", mem_alu_res, 32'h0000_0C00);

        // Memory stall with a flush arriving mid-stall
        pre(mk(1'b1, 32'h0000_1000, 5'd4, 1'b1));
        post();
        chk("ms cap mem_valid", 32'(mem_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            s = mk(1'b1, 32'h0000_9999, 5'd11, 1'b1); s.mstall = 1'b1; s.flush = (k == 1);
            pre(s);
            chk($sformatf("ms%0d ex_stall", k), 32'(ex_stall), 32'd1);
            post();
            chk($sformatf("ms%0d mem_alu_res", k), mem_alu_res, 32'h0000_1000);
            chk($sformatf("ms%0d mem_valid", k), 32'(mem_valid), 32'd1);
        end
        pre(mk(1'b1, 32'h0000_2222, 5'd12, 1'b1));
        chk("ms release ex_stall", 32'(ex_stall), 32'd0);
        post();
        chk("ms pending flush mem_valid", 32'(mem_valid), 32'd0);
        chk("ms pending flush res", mem_alu_res, 32'h0000_1000);
        pre(mk(1'b1, 32'h0000_3333, 5'd13, 1'b1));
        post();
        chk("ms after mem_valid", 32'(mem_valid), 32'd1);
        chk("ms after res", mem_alu_res, 32'h0000_3333);

        // ALU timeout, stickiness, then async reset mid-wait
        do_reset();
        for (int k = 1; k <= 41; k++) begin
            s = mk(1'b1, 32'h0, 5'd1, 1'b1); s.bubble = 1'b1;
            pre(s);
            post();
            if (k == 39) chk("to before", 32'(alu_timeout), 32'd0);
            if (k >= 40) chk($sformatf("to cyc%0d", k), 32'(alu_timeout), 32'd1);
            if (k == 41) chk("to still waiting", 32'(mem_valid), 32'd0);
        end
        pre(mk(1'b1, 32'h0000_ABCD, 5'd14, 1'b1));
        post();
        chk("to release res", mem_alu_res, 32'h0000_ABCD);
        chk("to sticky", 32'(alu_timeout), 32'd1);
        for (int k = 0; k < 3; k++) begin
            s = mk(1'b1, 32'h0, 5'd1, 1'b1); s.bubble = 1'b1;
            pre(s);
            post();
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst mem_valid", 32'(mem_valid), 32'd0);
        chk("arst mem_alu_res", mem_alu_res, 32'd0);
        chk("arst mem_rd", 32'(mem_rd), 32'd0);
        chk("arst alu_timeout", 32'(alu_timeout), 32'd0);
        chk("arst ex_stall", 32'(ex_stall), 32'd0);
        chk("arst fwd_valid", 32'(fwd_valid), 32'd0);

`ifdef STALL_COUNTERS_EN
        do_reset();
        for (int k = 0; k < 32; k++) begin
            s = mk(1'b1, 32'h0, 5'd2, 1'b1); s.bubble = 1'b1;
            pre(s); post();
        end
        pre(mk(1'b1, 32'h0000_00D1, 5'd2, 1'b1)); post();
        for (int k = 0; k < 4; k++) begin
            s = mk(1'b0, 32'h0, 5'd0, 1'b0); s.mstall = 1'b1;
            pre(s); post();
        end
        pre('0); post();
        chk("perf_alu_stall", perf_alu_stall, 32'd32);
        chk("perf_mem_stall", perf_mem_stall, 32'd4);
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 500; c++) begin
            s        = '0;
            s.v      = ($urandom % 4) != 0;
            s.res    = $urandom;
            s.sd     = $urandom;
            s.rd     = 5'($urandom % 8);
            s.rw     = $urandom % 2;
            s.mr     = $urandom % 2;
            s.mw     = $urandom % 2;
            s.f3     = 3'($urandom % 8);
            s.bubble = m_waiting ? (($urandom % 6) != 0) : (($urandom % 5) == 0);
            s.mstall = ($urandom % 7) == 0;
            s.flush  = ($urandom % 12) == 0;
            pre(s);
            chk("rnd ex_stall", 32'(ex_stall), 32'(model_stall(s)));
            post();
            model_step(s);
            chk("rnd mem_valid", 32'(mem_valid), 32'(m_valid));
            chk("rnd fwd_valid", 32'(fwd_valid), 32'(m_valid & m_cap.rw & (m_cap.rd != 5'd0)));
            chk("rnd alu_timeout", 32'(alu_timeout), 32'(m_timeout));
            if (m_valid) begin
                chk("rnd mem_alu_res", mem_alu_res, m_cap.res);
                chk("rnd mem_store_data", mem_store_data, m_cap.sd);
                chk("rnd mem_rd", 32'(mem_rd), 32'(m_cap.rd));
                chk("rnd ctrl", {29'd0, mem_reg_write, mem_mem_read, mem_mem_write},
                    {29'd0, m_cap.rw, m_cap.mr, m_cap.mw});
                chk("rnd funct3", 32'(mem_funct3), 32'(m_cap.f3));
                chk("rnd fwd_rd", 32'(fwd_rd), 32'(m_cap.rd));
                chk("rnd fwd_data", fwd_data, m_cap.res);
            end
`ifdef STALL_COUNTERS_EN
            chk("rnd perf_alu", perf_alu_stall, 32'(m_palu));
            chk("rnd perf_mem", perf_mem_stall, 32'(m_pmem));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
EX/MEM pipeline boundary sitting directly downstream of the ALU. It captures the ALU result and its control bundle, and holds the upstream pipe while the ALU signals multicycle ops via insert_bubble or the data memory stalls. It emits a bubble (invalid slot) to MEM while a multicycle op runs. It also drives the forwarding source for the EX-stage operand muxes.

Parameters:
DATA_W, 32, datapath width
REG_ADDR_W, 5, register index width
MAX_BUBBLE, 40, ALU wait cycles before alu_timeout is raised

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ex_valid  in  1  ID/EX holds a live instruction
ex_alu_res  in  DATA_W  ALU result (alu_res)
ex_store_data  in  DATA_W  rs2 value for stores
ex_rd  in  REG_ADDR_W  destination register
ex_reg_write  in  1  writes rd
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_funct3  in  3  load/store size/sign
alu_insert_bubble  in  1  ALU insert_bubble
mem_stall  in  1  data memory busy, MEM must hold
flush  in  1  kill the instruction currently in EX
ex_stall  out  1  hold PC, IF/ID, ID/EX this cycle
mem_valid  out  1  MEM slot live
mem_alu_res  out  DATA_W  registered result/address
mem_store_data  out  DATA_W  registered store data
mem_rd  out  REG_ADDR_W  registered rd
mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered controls
mem_funct3  out  3  registered funct3
fwd_valid  out  1  mem_valid & mem_reg_write & (mem_rd != 0)
fwd_rd  out  REG_ADDR_W  equals mem_rd
fwd_data  out  DATA_W  equals mem_alu_res
alu_timeout  out  1  sticky error

Behaviour:
- Reset: all registered outputs, state, counters, flush_pending and alu_timeout = 0; state = RUN.
- States: RUN, ALU_WAIT, MEM_HOLD.
- Priority per cycle: mem_stall > flush > alu_insert_bubble > capture.
- mem_stall=1 (any state): go to MEM_HOLD; all mem_* hold; ex_stall=1. On mem_stall falling, re-evaluate the same cycle with RUN rules.
- flush=1 while mem_stall=0: next mem_valid=0, no capture, ex_stall=0. If flush arrives during mem_stall, set flush_pending; apply on the first non-stalled cycle, then clear it.
- RUN, ex_valid & alu_insert_bubble: ex_stall=1; next mem_valid=0; wait_cnt<=1; go to ALU_WAIT.
- ALU_WAIT: ex_stall = alu_insert_bubble. mem_valid stays 0 and wait_cnt increments each cycle.
  - When alu_insert_bubble=0, capture ex_* that cycle, next mem_valid=1, return to RUN.
  - wait_cnt == MAX_BUBBLE sets alu_timeout, which stays set until reset. The state machine keeps waiting.
- RUN, ex_valid & !alu_insert_bubble: capture; latency 1 cycle; ex_stall=0.
- ex_valid=0: next mem_valid=0. Data registers may hold stale values; consumers qualify with mem_valid.
- Result capture is always from ex_alu_res in the cycle bubble drops. The ALU guarantees the result is valid that cycle.
- Forwarding outputs are combinational from the registers and respect the x0 rule.
- Reset mid-ALU_WAIT: immediate return to RUN with all outputs 0.

Optional Feature:
- STALL_COUNTERS_EN defined: add outputs perf_alu_stall (32) and perf_mem_stall (32).
  - Counters reset to 0 and saturate at all-ones.
  - perf_alu_stall increments each cycle ex_stall is caused by ALU_WAIT or by bubble entry.
  - perf_mem_stall increments each mem_stall cycle.
- Not defined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- common_pkg gains ex_mem_state_t (RUN, ALU_WAIT, MEM_HOLD) and ex_mem_bundle_t, a packed struct of all ex_*/mem_* payload fields, so capture/hold is a single register.
- Sub-module sat_counter (WIDTH param, inc, count) is instantiated twice under STALL_COUNTERS_EN.

Test Plan:
1. ex_valid=1, ex_alu_res=0x0000_0042, rd=5, reg_write=1, no bubble -> next cycle mem_valid=1, mem_alu_res=0x42, fwd_valid=1, fwd_rd=5, ex_stall=0.
2. MUL with alu_insert_bubble high 6 cycles, then low with res 0x0000_0C00 -> ex_stall=1 for 6 cycles, mem_valid=0 throughout, then mem_valid=1 with 0x0C00 one cycle after the drop.
3. mem_stall high 3 cycles with mem_alu_res=0x1000 -> mem_* unchanged, ex_stall=1; flush pulsed mid-stall -> mem_valid=0 on first cycle after stall ends.
4. rd=0, reg_write=1, ex_alu_res=0xFFFF_FFFF -> mem_valid=1, fwd_valid=0.
5. alu_insert_bubble held 41 cycles -> alu_timeout=1 from cycle 40 and stays set until rst; assert rst in ALU_WAIT -> all outputs 0 immediately, asynchronously.
6. With STALL_COUNTERS_EN: 32-cycle DIV bubble then 4-cycle mem_stall -> perf_alu_stall=32, perf_mem_stall=4.
